xc_malu_muldiv_iter: RTL

//  Self-contained, parametrised iterative multiply/divide unit. Successor to the shared-state muldivrem router.
//  It owns its operand, accumulator and counter registers and runs its own FSM with a valid/ready handshake.

---
 rtl/xc_malu_muldiv_iter_pkg.sv | 28 ++
 rtl/xc_malu_muldiv_iter_divstep.sv | 29 ++
 rtl/xc_malu_muldiv_iter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/xc_malu_muldiv_iter_pkg.sv
// rtl/xc_malu_muldiv_iter_pkg.sv - op encodings and FSM states for the iterative mul/div unit
// Shared by the unit and anything that decodes XC_MD_* operations.
package xc_malu_muldiv_iter_pkg;

   localparam int XC_MD_OP_W = 4;

   typedef enum logic [XC_MD_OP_W-1:0] {
      XC_MD_MUL    = 4'd0,
      XC_MD_MULH   = 4'd1,
      XC_MD_MULHU  = 4'd2,
      XC_MD_MULHSU = 4'd3,
      XC_MD_CLMUL  = 4'd4,
      XC_MD_CLMULH = 4'd5,
      XC_MD_DIV    = 4'd6,
      XC_MD_DIVU   = 4'd7,
      XC_MD_REM    = 4'd8,
      XC_MD_REMU   = 4'd9
   } xc_md_op_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } md_state_t;

endpackage

// File: rtl/xc_malu_muldiv_iter_divstep.sv
// rtl/xc_malu_muldiv_iter_divstep.sv - one combinational restoring-division step
// Ports:
//   rem      in   XLEN  partial remainder so far
//   msb      in   1     next dividend bit to bring down
//   divisor  in   XLEN  divisor magnitude
//   rem_nxt  out  XLEN  partial remainder after this step
//   q_bit    out  1     quotient bit produced by this step
module xc_malu_muldiv_iter_divstep #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem,
   input  logic            msb,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_nxt,
   output logic            q_bit
);

   logic [XLEN:0] trial;
   logic [XLEN:0] diff;

   always_comb begin
      trial   = {rem, msb};
      diff    = trial - {1'b0, divisor};
      // No borrow out of the top bit means the divisor fits.
      q_bit   = ~diff[XLEN];
      rem_nxt = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
   end

endmodule

// File: rtl/xc_malu_muldiv_iter.sv
// rtl/xc_malu_muldiv_iter.sv - iterative multiply / carry-less multiply / divide / remainder unit
// Ports:
//   clock   in   1       rising-edge clock
//   resetn  in   1       synchronous active-low reset
//   flush   in   1       abandon current operation, back to IDLE
//   valid   in   1       request; accepted only in IDLE
//   rs1     in   XLEN    lhs / dividend, sampled at acceptance
//   rs2     in   XLEN    rhs / divisor, sampled at acceptance
//   op      in   4       XC_MD_* operation
//   busy    out  1       high in LOAD, RUN and FIX
//   ready   out  1       one-cycle pulse with result valid
//   result  out  2*XLEN  mul: {hi,lo}; div/rem: {zeros, value}
module xc_malu_muldiv_iter
   import xc_malu_muldiv_iter_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MUL_BPC   = 1,
   parameter int EARLY_OUT = 1
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              flush,
   input  logic              valid,
   input  logic [XLEN-1:0]   rs1,
   input  logic [XLEN-1:0]   rs2,
   input  logic [3:0]        op,
   output logic              busy,
   output logic              ready,
   output logic [2*XLEN-1:0] result
);

   localparam int            CW       = $clog2(XLEN);
   localparam logic [CW-1:0] LAST_MUL = CW'(XLEN / MUL_BPC - 1);
   localparam logic [CW-1:0] LAST_DIV = CW'(XLEN - 1);
   localparam logic [CW-1:0] BPC_W    = CW'(MUL_BPC);
   localparam bit            EO       = (EARLY_OUT != 0);

   md_state_t         state, state_nxt;
   logic [XLEN-1:0]   ra, rb;
   xc_md_op_t         op_q;
   logic [XLEN-1:0]   mag_a, arg_b, arg_q;
   logic [2*XLEN-1:0] acc;
   logic [CW-1:0]     count;
   logic              neg;

   logic              is_div, is_rem, is_cl, sgn_a, sgn_b, neg_a, neg_b;
   logic              div_zero, neg_res;
   logic [XLEN-1:0]   abs_a, abs_b, div_val;
   logic [CW-1:0]     last, shamt;
   logic [2*XLEN-1:0] pp, cl_pp, fix_val;
   logic [XLEN-1:0]   rem_nxt;
   logic              q_bit;

   // Operation decode and operand magnitudes, all from the values latched at acceptance.
   always_comb begin
      is_div   = (op_q == XC_MD_DIV) || (op_q == XC_MD_DIVU) ||
                 (op_q == XC_MD_REM) || (op_q == XC_MD_REMU);
      is_rem   = (op_q == XC_MD_REM) || (op_q == XC_MD_REMU);
      is_cl    = (op_q == XC_MD_CLMUL) || (op_q == XC_MD_CLMULH);
      sgn_a    = (op_q == XC_MD_MUL) || (op_q == XC_MD_MULH) || (op_q == XC_MD_MULHSU) ||
                 (op_q == XC_MD_DIV) || (op_q == XC_MD_REM);
      sgn_b    = (op_q == XC_MD_MUL) || (op_q == XC_MD_MULH) ||
                 (op_q == XC_MD_DIV) || (op_q == XC_MD_REM);
      neg_a    = sgn_a && ra[XLEN-1];
      neg_b    = sgn_b && rb[XLEN-1];
      // -2^(XLEN-1) negates to itself, which is its correct unsigned magnitude.
      abs_a    = neg_a ? -ra : ra;
      abs_b    = neg_b ? -rb : rb;
      div_zero = is_div && (rb == '0);
      if (is_rem)
         neg_res = neg_a;
      else if (is_div)
         neg_res = (neg_a ^ neg_b) && (rb != '0);
      else
         neg_res = neg_a ^ neg_b;
      last     = is_div ? LAST_DIV : LAST_MUL;
   end

   // Partial products for this iteration: integer and carry-less variants.
   always_comb begin
      shamt = count * BPC_W;
      pp    = {{XLEN{1'b0}}, mag_a} * {{(2*XLEN-MUL_BPC){1'b0}}, arg_b[MUL_BPC-1:0]};
      cl_pp = '0;
      for (int j = 0; j < MUL_BPC; j++) begin
         if (arg_b[j])
            cl_pp = cl_pp ^ ({{XLEN{1'b0}}, mag_a} << j);
      end
   end

   // Division: partial remainder lives in acc[XLEN-1:0], dividend shifts out of arg_q
   // while quotient bits shift in at the bottom.
   xc_malu_muldiv_iter_divstep #(.XLEN(XLEN)) u_divstep (
      .rem     (acc[XLEN-1:0]),
      .msb     (arg_q[XLEN-1]),
      .divisor (arg_b),
      .rem_nxt (rem_nxt),
      .q_bit   (q_bit)
   );

   always_comb begin
      div_val = is_rem ? acc[XLEN-1:0] : arg_q;
      if (is_div)
         fix_val = {{XLEN{1'b0}}, (neg ? -div_val : div_val)};
      else
         fix_val = neg ? -acc : acc;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (valid) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = (div_zero && EO) ? S_FIX : S_RUN;
         S_RUN:   if (count == last) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flush)
         state_nxt = S_IDLE;
   end

   assign busy  = (state == S_LOAD) || (state == S_RUN) || (state == S_FIX);
   assign ready = (state == S_DONE);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state  <= S_IDLE;
         ra     <= '0;
         rb     <= '0;
         op_q   <= XC_MD_MUL;
         mag_a  <= '0;
         arg_b  <= '0;
         arg_q  <= '0;
         acc    <= '0;
         count  <= '0;
         neg    <= 1'b0;
         result <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (valid && !flush) begin
                  ra   <= rs1;
                  rb   <= rs2;
                  op_q <= xc_md_op_t'(op);
               end
            end
            S_LOAD: begin
               mag_a <= abs_a;
               arg_b <= abs_b;
               count <= '0;
               neg   <= neg_res;
               if (div_zero && EO) begin
                  // Skipping RUN: preload what the restoring loop would produce for /0.
                  arg_q <= '1;
                  acc   <= {{XLEN{1'b0}}, abs_a};
               end else begin
                  arg_q <= abs_a;
                  acc   <= '0;
               end
            end
            S_RUN: begin
               count <= count + CW'(1);
               if (is_div) begin
                  arg_q <= {arg_q[XLEN-2:0], q_bit};
                  acc   <= {{XLEN{1'b0}}, rem_nxt};
               end else begin
                  arg_b <= arg_b >> MUL_BPC;
                  acc   <= is_cl ? (acc ^ (cl_pp << shamt)) : (acc + (pp << shamt));
               end
            end
            S_FIX: result <= fix_val;
            default: ;
         endcase
      end
   end

endmodule
